// File: rtl/simd_pkg.sv
// Shared opcode map, field slices and register-address decode for the SIMD issue stage.
package simd_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_MAC = 4'd3;
  localparam logic [3:0] OP_ABS = 4'd4;
  localparam logic [3:0] OP_SHR = 4'd5;
  localparam logic [3:0] OP_NEG = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_AND = 4'd8;
  localparam logic [3:0] OP_OR  = 4'd9;
  localparam logic [3:0] OP_XOR = 4'd10;
  localparam logic [3:0] OP_NOT = 4'd11;

  localparam logic [11:0] NOP_WORD = 12'hFF0;

  function automatic logic [3:0] op_f(input logic [11:0] instr);
    return instr[11:8];
  endfunction

  function automatic logic [1:0] bw_f(input logic [11:0] instr);
    return instr[7:6];
  endfunction

  function automatic logic [1:0] fc_f(input logic [11:0] instr);
    return instr[5:4];
  endfunction

  function automatic logic [1:0] fb_f(input logic [11:0] instr);
    return instr[3:2];
  endfunction

  function automatic logic [1:0] fa_f(input logic [11:0] instr);
    return instr[1:0];
  endfunction

  function automatic logic [15:0] onehot16(input logic [3:0] addr);
    return 16'(1) << addr;
  endfunction

  function automatic logic [3:0] dest_addr(input logic [11:0] instr);
    return {bw_f(instr), fc_f(instr)};
  endfunction

  // Long-form logic ops read a full 4-bit register from {fb,fa} instead of a bank-relative one.
  function automatic logic [15:0] src_mask(input logic [11:0] instr);
    logic [15:0] a, b, c, l, m;
    a = onehot16({bw_f(instr), fa_f(instr)});
    b = onehot16({bw_f(instr), fb_f(instr)});
    c = onehot16({bw_f(instr), fc_f(instr)});
    l = onehot16({fb_f(instr), fa_f(instr)});
    m = '0;
    case (op_f(instr))
      OP_ADD, OP_SUB, OP_MUL: m = a | b;
      OP_MAC:                 m = a | b | c;
      OP_ABS, OP_NEG:         m = a;
      OP_AND, OP_OR, OP_XOR:  m = l | c;
      OP_NOT:                 m = l;
      OP_SHR, OP_MOV:         m = '0;
      default:                m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Register-array FIFO; the head word is always visible on rdata for the issue decision.
module issue_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/simd_issue_queue.sv
// Issue stage: buffers instructions and inserts NOPs until read-after-write spacing to the core is safe.
module simd_issue_queue
  import simd_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int HAZ_DIST = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [11:0]            in_instr,
  output logic                   in_ready,
  input  logic                   run,
  output logic [11:0]            instruction,
  output logic                   issue_valid,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0]            stall_count
);
  localparam int HIST = HAZ_DIST - 1;
  localparam int HN   = (HIST > 0) ? HIST : 1;

  logic [11:0]   head;
  logic          empty, full, push;
  logic          hazard_p0, issue_p0, stall_p0;
  logic [15:0]   hist_mask;
  logic [HN-1:0] hist_vld;
  logic [3:0]    hist_dst [HN];

  issue_fifo #(.DEPTH(DEPTH), .WIDTH(12)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (issue_p0),
    .wdata (in_instr),
    .rdata (head),
    .count (fifo_count),
    .empty (empty),
    .full  (full)
  );

  assign in_ready = !full;
  assign push     = in_valid && !full;

  // Stage p0: hazard decision against the destinations of the last HIST issue slots.
  always_comb begin
    hist_mask = '0;
    for (int i = 0; i < HIST; i++) begin
      if (hist_vld[i]) hist_mask[hist_dst[i]] = 1'b1;
    end
  end

  assign hazard_p0 = |(src_mask(head) & hist_mask);
  assign issue_p0  = run && !empty && !hazard_p0;
  assign stall_p0  = run && !empty && hazard_p0;

  // Stage p1: registered word to the core, history shift and stall statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction <= NOP_WORD;
      issue_valid <= 1'b0;
      hist_vld    <= '0;
      stall_count <= '0;
    end else begin
      instruction <= issue_p0 ? head : NOP_WORD;
      issue_valid <= issue_p0;
      hist_vld[0] <= issue_p0;
      for (int i = 1; i < HN; i++) hist_vld[i] <= hist_vld[i-1];
      if (stall_p0 && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end

  // Destination tags need no reset: the valid bits gate them.
  always_ff @(posedge clk) begin
    hist_dst[0] <= dest_addr(head);
    for (int i = 1; i < HN; i++) hist_dst[i] <= hist_dst[i-1];
  end

endmodule

// File: tb/tb_simd_issue_queue.sv
// Bench for simd_issue_queue: queue/history reference model, per-cycle compare, directed and random traffic.
module tb_simd_issue_queue;
  localparam int DEPTH = 8;
  localparam int HD    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [11:0] in_instr = 12'h000;
  logic        run = 1'b0;

  logic        in_ready, issue_valid, in_ready1, issue_valid1;
  logic [11:0] instruction, instruction1;
  logic [3:0]  fifo_count, fifo_count1;
  logic [15:0] stall_count, stall_count1;

  always #5 clk = ~clk;

  simd_issue_queue #(.DEPTH(DEPTH), .HAZ_DIST(HD)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .run(run), .instruction(instruction), .issue_valid(issue_valid),
    .fifo_count(fifo_count), .stall_count(stall_count)
  );

  simd_issue_queue #(.DEPTH(DEPTH), .HAZ_DIST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready1),
    .run(run), .instruction(instruction1), .issue_valid(issue_valid1),
    .fifo_count(fifo_count1), .stall_count(stall_count1)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  bit          chk_en = 0;
  logic [11:0] mq[$];
  int          mh[$];
  logic [11:0] m_instr = 12'hFF0;
  bit          m_vld = 0;
  int          m_stall = 0;
  logic [11:0] log_all[$], log_vld[$], log1_all[$];

  typedef int iq_t[$];
  typedef logic [11:0] wq_t[$];

  function automatic void check(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic int dst(logic [11:0] w);
    return int'({w[7:6], w[5:4]});
  endfunction

  function automatic iq_t srcs(logic [11:0] w);
    iq_t s;
    int a, b, c, l;
    a = int'({w[7:6], w[1:0]});
    b = int'({w[7:6], w[3:2]});
    c = int'({w[7:6], w[5:4]});
    l = int'({w[3:2], w[1:0]});
    case (w[11:8])
      4'd0, 4'd1, 4'd2: begin s.push_back(a); s.push_back(b); end
      4'd3:             begin s.push_back(a); s.push_back(b); s.push_back(c); end
      4'd4, 4'd6:       s.push_back(a);
      4'd8, 4'd9, 4'd10: begin s.push_back(l); s.push_back(c); end
      4'd11:            s.push_back(l);
      default:          ;
    endcase
    return s;
  endfunction

  function automatic bit blocked(logic [11:0] w);
    iq_t s = srcs(w);
    foreach (s[i]) foreach (mh[j]) if (mh[j] == s[i]) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    mq.delete();
    mh.delete();
    m_instr = 12'hFF0;
    m_vld   = 0;
    m_stall = 0;
  endtask

  // One clock edge of the reference: issue decision on pre-edge state, then accept the push.
  task automatic model_step(output bit acc);
    int n = mq.size();
    bit haz = (n > 0) ? blocked(mq[0]) : 0;
    if (run && n > 0 && !haz) begin
      m_instr = mq[0];
      m_vld   = 1;
      mh.push_front(dst(mq[0]));
      void'(mq.pop_front());
    end else begin
      m_instr = 12'hFF0;
      m_vld   = 0;
      mh.push_front(-1);
      if (run && n > 0 && m_stall < 65535) m_stall++;
    end
    while (mh.size() > HD - 1) void'(mh.pop_back());
    acc = in_valid && (n < DEPTH);
    if (acc) mq.push_back(in_instr);
  endtask

  task automatic cycle(input bit v, input logic [11:0] w, input bit r, output bit acc);
    @(negedge clk);
    in_valid = v;
    in_instr = w;
    run      = r;
    @(posedge clk);
    acc = 0;
    if (rst_n) model_step(acc);
  endtask

  task automatic idle(input int n, input bit r);
    bit acc;
    for (int i = 0; i < n; i++) cycle(0, 12'h000, r, acc);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 0;
    run      = 0;
    #2 rst_n = 0;
    model_reset();
    chk_en = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;
    log_all.delete();
    log_vld.delete();
    log1_all.delete();
  endtask

  task automatic seq_check(string name, input wq_t lg, input wq_t exp);
    int idx = -1;
    foreach (lg[i]) if (idx < 0 && lg[i] == exp[0]) idx = i;
    check({name, "_found"}, int'(idx >= 0), 1);
    if (idx >= 0) begin
      for (int k = 1; k < exp.size(); k++)
        check(name, (idx + k < lg.size()) ? int'(lg[idx+k]) : -1, int'(exp[k]));
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("instruction", int'(instruction), int'(m_instr));
      check("issue_valid", int'(issue_valid), int'(m_vld));
      check("fifo_count", int'(fifo_count), mq.size());
      check("in_ready", int'(in_ready), int'(mq.size() < DEPTH));
      check("stall_count", int'(stall_count), m_stall);
      log_all.push_back(instruction);
      if (issue_valid) log_vld.push_back(instruction);
      log1_all.push_back(instruction1);
    end
  end

  initial begin
    bit acc, pv;
    logic [11:0] pw;

    // Reset state.
    do_reset();
    #1;
    check("rst_instruction", int'(instruction), 12'hFF0);
    check("rst_issue_valid", int'(issue_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_fifo_count", int'(fifo_count), 0);

    // Independent back-to-back words.
    do_reset();
    cycle(1, 12'h024, 1, acc);
    cycle(1, 12'h031, 1, acc);
    idle(4, 1);
    settle();
    seq_check("t2_seq", log_all, '{12'h024, 12'h031});
    check("t2_stall", int'(stall_count), 0);

    // Reader of reg2 right behind its writer.
    do_reset();
    cycle(1, 12'h024, 1, acc);
    cycle(1, 12'h139, 1, acc);
    idle(4, 1);
    settle();
    seq_check("t3_seq", log_all, '{12'h024, 12'hFF0, 12'h139});
    check("t3_stall", int'(stall_count), 1);

    // Long-form AND reading reg6; the HAZ_DIST=1 instance must not stall.
    do_reset();
    cycle(1, 12'h064, 1, acc);
    cycle(1, 12'h806, 1, acc);
    idle(4, 1);
    settle();
    seq_check("t4_seq", log_all, '{12'h064, 12'hFF0, 12'h806});
    seq_check("t4_seq_hd1", log1_all, '{12'h064, 12'h806});
    check("t4_stall_hd1", int'(stall_count1), 0);

    // Fill while held, overflow attempt, then drain.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 12'h500 | 12'(i), 0, acc);
    cycle(1, 12'h5AB, 0, acc);
    settle();
    check("t5_fifo_count", int'(fifo_count), 8);
    check("t5_in_ready", int'(in_ready), 0);
    idle(12, 1);
    settle();
    check("t5_drain_len", log_vld.size(), 8);
    for (int i = 0; i < 8; i++)
      check("t5_drain_word", (i < log_vld.size()) ? int'(log_vld[i]) : -1, 12'h500 + i);

    // Asynchronous reset with words queued and one in flight.
    do_reset();
    cycle(1, 12'h024, 0, acc);
    cycle(1, 12'h031, 0, acc);
    cycle(1, 12'h500, 0, acc);
    cycle(0, 12'h000, 1, acc);
    @(negedge clk);
    run = 0;
    #2 rst_n = 0;
    model_reset();
    #1;
    check("t6_rst_instruction", int'(instruction), 12'hFF0);
    check("t6_rst_issue_valid", int'(issue_valid), 0);
    check("t6_rst_fifo_count", int'(fifo_count), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    log_vld.delete();
    idle(6, 1);
    settle();
    check("t6_no_stale", log_vld.size(), 0);

    // Random traffic with a source that holds its word until accepted.
    do_reset();
    pv = 0;
    pw = 12'h000;
    for (int i = 0; i < 3000; i++) begin
      bit r;
      if (!pv && $urandom_range(0, 3) != 0) begin
        pv = 1;
        pw = 12'($urandom);
      end
      r = ((i % 500) < 120) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) != 0);
      cycle(pv, pw, r, acc);
      if (acc) pv = 0;
    end
    idle(20, 1);
    settle();
    chk_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
